// File: rtl/packetizer_2.sv
// Two-flit packetizer: wraps a payload with routing fields into head/tail flits
// and buffers it in a two-entry skid buffer so ready_out can be a register.
module packetizer_2 #(
  parameter int WIDTH_PKT        = 36,
  parameter int WIDTH_DATA       = 12,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_DATA-1:0]       data_in,
  input  logic [ADDRESS_WIDTH-1:0]    dest_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic [WIDTH_PKT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [15:0]                 pkt_count
);

  localparam int WIDTH_FLIT     = WIDTH_PKT / 2;
  localparam int WIDTH_DATA_IDL = WIDTH_PKT - 6 - 2*VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int EXTRA_BITS     = WIDTH_DATA_IDL - WIDTH_DATA;
  localparam int HEAD_DATA      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int TAIL_DATA      = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;

  if (EXTRA_BITS < 0) begin : g_width_check
    $error("packetizer_2: WIDTH_DATA exceeds the payload capacity of one packet");
  end

  logic [WIDTH_DATA_IDL-1:0] full_data;
  logic [WIDTH_FLIT-1:0]     head_flit;
  logic [WIDTH_FLIT-1:0]     tail_flit;
  logic [WIDTH_PKT-1:0]      pkt_new;

  // Payload is MSB-aligned; the unused low bits of the tail are zero.
  assign full_data = WIDTH_DATA_IDL'(data_in) << EXTRA_BITS;
  assign head_flit = {1'b1, 1'b1, 1'b0, vc_in, dest_in,
                      full_data[WIDTH_DATA_IDL-1 -: HEAD_DATA]};
  assign tail_flit = {1'b1, 1'b0, 1'b1, vc_in, full_data[TAIL_DATA-1:0]};
  assign pkt_new   = {head_flit, tail_flit};

  logic [WIDTH_PKT-1:0] main_q, main_d;
  logic [WIDTH_PKT-1:0] skid_q, skid_d;
  logic                 main_vld_q, main_vld_d;
  logic                 skid_vld_q, skid_vld_d;
  logic                 ready_q;
  logic [15:0]          cnt_q, cnt_d;
  logic                 accept;
  logic                 deliver;

  assign accept  = valid_in && ready_q;
  assign deliver = main_vld_q && ready_in;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (deliver) begin
      cnt_d = cnt_q + 16'd1;
      if (skid_vld_q) begin
        // ready_q is low whenever the skid is occupied, so no accept here.
        main_d     = skid_q;
        skid_d     = '0;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = pkt_new;
      end else begin
        main_d     = '0;
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_vld_q) begin
        main_d     = pkt_new;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = pkt_new;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= !skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_out = ready_q;
  assign data_out  = main_q;
  assign valid_out = main_vld_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_packetizer_2.sv
// Directed + random bench for packetizer_2 with a packet scoreboard.
module tb_packetizer_2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic [3:0]  dest_in;
  logic [0:0]  vc_in;
  logic        valid_in;
  logic        ready_out;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [15:0] pkt_count;

  packetizer_2 dut (
    .clk(clk), .rst(rst), .data_in(data_in), .dest_in(dest_in), .vc_in(vc_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [35:0] sb[$];
  logic [11:0] pay_q[$];
  logic [15:0] exp_cnt;
  bit          hold_pending;
  logic [35:0] held_data;
  bit          last_acc;

  function automatic logic [35:0] model(logic [11:0] d, logic [3:0] dst, logic [0:0] vc);
    logic [23:0] fd;
    logic [17:0] h, t;
    fd = {d, 12'h000};
    h  = {3'b110, vc, dst, fd[23:14]};
    t  = {3'b101, vc, fd[13:0]};
    return {h, t};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check current outputs against the model, account for the coming edge, advance.
  task automatic step();
    bit acc, dlv;
    logic [35:0] e;
    logic [23:0] fd;
    acc = valid_in && ready_out;
    dlv = valid_out && ready_in;
    if (hold_pending) begin
      chk("hold_valid", valid_out, 1'b1);
      chk("hold_data", data_out, held_data);
    end
    if (!valid_out) chk("idle_zero", data_out, 36'h0);
    chk("valid_out", valid_out, sb.size() > 0);
    chk("ready_out", ready_out, sb.size() < 2);
    chk("pkt_count", pkt_count, exp_cnt);
    if (dlv) begin
      if (sb.size() == 0) begin
        chk("extra_pkt", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("pkt_data", data_out, e);
        fd = {data_out[27:18], data_out[13:0]};
        chk("payload", fd[23:12], pay_q.pop_front());
      end
      exp_cnt = exp_cnt + 16'd1;
    end
    if (acc) begin
      sb.push_back(model(data_in, dest_in, vc_in));
      pay_q.push_back(data_in);
    end
    last_acc     = acc;
    hold_pending = valid_out && !ready_in;
    held_data    = data_out;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    pay_q.delete();
    exp_cnt      = 16'h0;
    hold_pending = 1'b0;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_data", data_out, 36'h0);
    chk("rst_cnt", pkt_count, 16'h0);
    chk("rst_ready", ready_out, 1'b1);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    data_in = '0; dest_in = '0; vc_in = '0;
    exp_cnt = 16'h0; hold_pending = 1'b0; last_acc = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Single packet with known encoding.
    data_in = 12'hABC; dest_in = 4'h5; vc_in = 1'b1; valid_in = 1'b1; ready_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("single_valid", valid_out, 1'b1);
    chk("single_data", data_out, 36'hD5ABEC000);
    step();
    chk("single_cnt", pkt_count, 16'd1);
    step();

    // Backpressure: two accepted, third held until skid drains.
    ready_in = 1'b0; valid_in = 1'b1; dest_in = 4'h3; vc_in = 1'b0;
    data_in = 12'd1; step();
    data_in = 12'd2; step();
    chk("bp_ready_low", ready_out, 1'b0);
    data_in = 12'd3; step();
    chk("bp_third_held", last_acc, 1'b0);
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_acc) valid_in = 1'b0;
    end
    chk("bp_drained", sb.size(), 0);
    chk("bp_cnt", pkt_count, 16'd4);

    // 100-packet stream at full rate.
    do_reset();
    ready_in = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      data_in = 12'(i * 37 + 5); dest_in = 4'(i); vc_in = 1'(i);
      step();
    end
    valid_in = 1'b0;
    step();
    chk("stream_cnt", pkt_count, 16'd100);

    // Reset while both entries are full.
    ready_in = 1'b0; valid_in = 1'b1;
    data_in = 12'h111; step();
    data_in = 12'h222; step();
    chk("full_ready_low", ready_out, 1'b0);
    valid_in = 1'b0;
    do_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Random valid/ready toggling.
    for (int i = 0; i < 10000; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      data_in  = 12'($urandom);
      dest_in  = 4'($urandom);
      vc_in    = 1'($urandom);
      step();
    end
    valid_in = 1'b0; ready_in = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("rand_drained", sb.size(), 0);

    // Counter wrap.
    do_reset();
    valid_in = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFE; i++) begin
      data_in = 12'(i);
      step();
    end
    chk("wrap_preload", pkt_count, 16'hFFFE);
    step();
    valid_in = 1'b0;
    step();
    chk("wrap_zero", pkt_count, 16'h0000);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/packetizer_2.md
PACKETIZER_2 -- requirements
Module: packetizer_2

Interface
REQ-001 Parameter WIDTH_PKT, default 36: packet width; two flits of WIDTH_PKT/2 (WIDTH_FLIT) bits each.
REQ-002 Parameter WIDTH_DATA, default 12: payload width per packet.
REQ-003 Parameter VC_ADDRESS_WIDTH, default 1: virtual-channel field width.
REQ-004 Parameter ADDRESS_WIDTH, default 4: destination field width.
REQ-005 Derived WIDTH_DATA_IDL = WIDTH_PKT - 6 - 2*VC_ADDRESS_WIDTH - ADDRESS_WIDTH; EXTRA_BITS = WIDTH_DATA_IDL - WIDTH_DATA; WIDTH_DATA > WIDTH_DATA_IDL SHALL be a compile-time error.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock; all state on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 data_in  input  WIDTH_DATA  payload.
REQ-010 dest_in  input  ADDRESS_WIDTH  destination router, sampled with data_in.
REQ-011 vc_in  input  VC_ADDRESS_WIDTH  virtual channel, sampled with data_in.
REQ-012 valid_in  input  1  payload valid.
REQ-013 ready_out  output  1  packetizer can accept.
REQ-014 data_out  output  WIDTH_PKT  two-flit packet.
REQ-015 valid_out  output  1  packet valid.
REQ-016 ready_in  input  1  NoC side can accept.
REQ-017 pkt_count  output  16  packets delivered since reset.

Function
REQ-018 Accept occurs when valid_in && ready_out at a clock edge; deliver occurs when valid_out && ready_in.
REQ-019 full_data = {data_in, EXTRA_BITS zeros} (payload MSB-aligned in WIDTH_DATA_IDL).
REQ-020 Head flit (data_out[WIDTH_PKT-1:WIDTH_FLIT]), MSB first: valid=1, head=1, tail=0, vc_in, dest_in, full_data upper (WIDTH_FLIT-3-VC_ADDRESS_WIDTH-ADDRESS_WIDTH) bits.
REQ-021 Tail flit (data_out[WIDTH_FLIT-1:0]), MSB first: valid=1, head=0, tail=1, vc_in, remaining lower full_data bits.
REQ-022 Packet SHALL be formed combinationally from inputs and captured in a two-entry skid buffer (main register, skid register), each with own valid bit.
REQ-023 data_out, valid_out SHALL be driven directly from main register; latency accept-to-valid_out = 1 cycle.
REQ-024 ready_out SHALL be registered: ready_out = !skid_valid.
REQ-025 Accept with main empty, or main delivering and skid empty: packet to main.
REQ-026 Accept with main full and not delivering: packet to skid; ready_out low next cycle.
REQ-027 Deliver with skid full: main <= skid, skid emptied, ready_out high next cycle; simultaneous accept impossible (ready_out low).
REQ-028 Deliver with skid empty and no accept: main emptied; data_out SHALL be all zeros whenever valid_out is 0.
REQ-029 Packets SHALL be delivered in accept order; none dropped or duplicated; sustained throughput 1 packet/cycle when ready_in held high.
REQ-030 valid_out SHALL stay high and data_out stable until delivery (no retraction under backpressure).
REQ-031 pkt_count SHALL increment by 1 per deliver, wrapping 16'hFFFF -> 16'h0000.
REQ-032 Inputs other than valid_in are don't-care when valid_in is 0.

Reset
REQ-033 While rst high at an edge: main_valid=0, skid_valid=0, valid_out=0, data_out=0, pkt_count=0, ready_out=1 from next cycle.
REQ-034 Reset mid-operation SHALL discard buffered packets; no accept or deliver is counted in the reset cycle.
REQ-035 The first accept is possible on the first edge after rst deasserts.

Verification
REQ-036 Defaults, data_in=12'hABC, dest_in=4'h5, vc_in=1, ready_in=1 -> next cycle valid_out=1, data_out=36'hD5ABEC000, pkt_count then 1.
REQ-037 ready_in=0, three back-to-back accepts 1,2,3 -> first two accepted, ready_out=0 after second, third held; release ready_in -> delivered 1,2,3 in order, no gap.
REQ-038 ready_in=1, valid_in high 100 cycles with incrementing payload -> 100 packets out consecutively, pkt_count=100, payload round-trips through depacketizer_2 unchanged.
REQ-039 Preload pkt_count to 16'hFFFE by deliveries, deliver 2 more -> pkt_count=16'h0000.
REQ-040 Both entries full, assert rst one cycle -> valid_out=0, data_out=0, pkt_count=0, ready_out=1 next cycle, no stale packet emitted.
REQ-041 Random valid_in/ready_in toggling, 10k cycles -> scoreboard order match, valid_out never drops before deliver.
